systolic_mm_engine: RTL and testbench

//  Parametrised NxN output-stationary systolic matrix multiplier: C = A(NxK) * B(KxN), K runtime-set.

---
 rtl/systolic_mm_engine_pkg.sv | 23 ++
 rtl/systolic_mm_engine_pe.sv | 50 +++++
 rtl/systolic_mm_engine.sv | 180 ++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_mm_engine_pkg.sv
// Shared types and constant helpers for the systolic matrix-multiply engine.
package systolic_mm_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Cycles from the last accepted beat until the far corner PE has folded it in.
  function automatic int drain_lat(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_mm_engine_pe.sv
// Output-stationary processing element: registered a/b pass-through plus a
// multiply-accumulate whose product is sign- or zero-extended per job mode.
module systolic_mm_engine_pe #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  signed_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [PW-1:0]         a_ext, b_ext, prod;
  logic [ACC_WIDTH-1:0]  prod_ext;

  // A double-width product of extended operands is exact for both modes.
  always_comb begin
    a_ext    = signed_i ? PW'($signed(a_i)) : PW'(a_i);
    b_ext    = signed_i ? PW'($signed(b_i)) : PW'(b_i);
    prod     = a_ext * b_ext;
    prod_ext = signed_i ? ACC_WIDTH'($signed(prod)) : ACC_WIDTH'(prod);
    acc_d    = clear_i ? '0 : acc_q + prod_ext;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// NxN output-stationary systolic multiplier C = A(NxK) * B(KxN) with input skew,
// beat handshake, signed/unsigned and accumulate modes.
//   state    | meaning
//   ST_IDLE  | waiting for start, zeros fed
//   ST_LOAD  | accepting K beats, bubbles inject zeros
//   ST_DRAIN | last beat travelling to the far corner PE
//   ST_DONE  | res_o final and held until a clearing start
module systolic_mm_engine
  import systolic_mm_engine_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
  parameter int MAX_K      = 256
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [clog2(MAX_K+1)-1:0]       k_len_i,
  input  logic                            signed_i,
  input  logic                            acc_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [N*DATA_WIDTH-1:0]         a_col_i,
  input  logic [N*DATA_WIDTH-1:0]         b_row_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [N*N*ACC_WIDTH-1:0]        res_o
);

  localparam int DW = DATA_WIDTH;
  localparam int KW = clog2(MAX_K + 1);
  localparam int CW = clog2(drain_lat(N));
  localparam logic [KW-1:0] MAX_K_L    = KW'(MAX_K);
  localparam logic [CW-1:0] DRAIN_INIT = CW'(drain_lat(N) - 1);

  state_e          state_q;
  logic [KW-1:0]   beats_left_q;
  logic [CW-1:0]   drain_cnt_q;
  logic            signed_q;
  logic            in_ready_q, busy_q, done_q;
  logic [KW-1:0]   k_eff;
  logic            start_ok, clear_acc, beat_acc;

  assign k_eff     = (k_len_i > MAX_K_L) ? MAX_K_L : k_len_i;
  assign start_ok  = start_i & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign clear_acc = start_ok & ~acc_i;
  assign beat_acc  = in_valid_i & in_ready_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      beats_left_q <= '0;
      drain_cnt_q  <= '0;
      signed_q     <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            signed_q     <= signed_i;
            beats_left_q <= k_eff;
            if (k_eff == '0) begin
              state_q    <= ST_DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q    <= ST_LOAD;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (beat_acc) begin
            beats_left_q <= beats_left_q - KW'(1);
            if (beats_left_q == KW'(1)) begin
              state_q     <= ST_DRAIN;
              in_ready_q  <= 1'b0;
              drain_cnt_q <= DRAIN_INIT;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o = in_ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

  // Common input register: anything other than an accepted beat becomes zero.
  logic [N*DW-1:0] a_in_q, b_in_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_in_q <= '0;
      b_in_q <= '0;
    end else if (beat_acc) begin
      a_in_q <= a_col_i;
      b_in_q <= b_row_i;
    end else begin
      a_in_q <= '0;
      b_in_q <= '0;
    end
  end

  logic [DW-1:0] a_h [N][N+1];
  logic [DW-1:0] b_v [N+1][N];

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_h[0][0] = a_in_q[0 +: DW];
      assign b_v[0][0] = b_in_q[0 +: DW];
    end else begin : g_dly
      logic [DW-1:0] a_sr_q [0:i-1];
      logic [DW-1:0] b_sr_q [0:i-1];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int d = 0; d < i; d++) begin
            a_sr_q[d] <= '0;
            b_sr_q[d] <= '0;
          end
        end else begin
          a_sr_q[0] <= a_in_q[i*DW +: DW];
          b_sr_q[0] <= b_in_q[i*DW +: DW];
          for (int d = 1; d < i; d++) begin
            a_sr_q[d] <= a_sr_q[d-1];
            b_sr_q[d] <= b_sr_q[d-1];
          end
        end
      end

      assign a_h[i][0] = a_sr_q[i-1];
      assign b_v[0][i] = b_sr_q[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_mm_engine_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (clear_acc),
        .signed_i (signed_q),
        .a_i      (a_h[i][j]),
        .b_i      (b_v[i][j]),
        .a_o      (a_h[i][j+1]),
        .b_o      (b_v[i+1][j]),
        .acc_o    (res_o[(i*N+j)*ACC_WIDTH +: ACC_WIDTH])
      );
    end
  end

  // Operands leaving the right and bottom edges have no consumer.
  logic [N*DW-1:0] unused_a_edge, unused_b_edge;
  for (genvar i = 0; i < N; i++) begin : g_edge
    assign unused_a_edge[i*DW +: DW] = a_h[i][N];
    assign unused_b_edge[i*DW +: DW] = b_v[N][i];
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Randomised bench for systolic_mm_engine against a plain-arithmetic matrix model.
module tb_systolic_mm_engine;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 2*DW+8;
  localparam int MK = 256;
  localparam int LAT = 2*N-1;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [8:0]        k_len_i = '0;
  logic              signed_i = 1'b0;
  logic              acc_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [N*DW-1:0]   a_col_i = '0;
  logic [N*DW-1:0]   b_row_i = '0;
  logic              busy_o, done_o;
  logic [N*N*AW-1:0] res_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [DW-1:0] a_m [N][MK];
  logic [DW-1:0] b_m [MK][N];
  logic [AW-1:0] exp_c [N][N];

  systolic_mm_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAX_K(MK)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .k_len_i    (k_len_i),
    .signed_i   (signed_i),
    .acc_i      (acc_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .a_col_i    (a_col_i),
    .b_row_i    (b_row_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .res_o      (res_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] prod_ref(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit sgn);
    longint sa, sb;
    logic [63:0] pu;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return AW'(sa * sb);
    end
    pu = {32'h0, a} * {32'h0, b};
    return {8'h0, pu};
  endfunction

  function automatic int k_eff(input int k);
    return (k > MK) ? MK : k;
  endfunction

  task automatic model_job(input int k, input bit sgn, input bit accm);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (!accm) exp_c[i][j] = '0;
        for (int kk = 0; kk < k_eff(k); kk++)
          exp_c[i][j] = exp_c[i][j] + prod_ref(a_m[i][kk], b_m[kk][j], sgn);
      end
  endtask

  task automatic fill_t1();
    for (int k = 0; k < MK; k++)
      for (int i = 0; i < N; i++) begin
        a_m[i][k] = DW'(i*4 + k + 1);
        b_m[k][i] = DW'(i + 1);
      end
  endtask

  task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int k = 0; k < MK; k++)
      for (int i = 0; i < N; i++) begin
        a_m[i][k] = av;
        b_m[k][i] = bv;
      end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < MK; k++)
      for (int i = 0; i < N; i++) begin
        a_m[i][k] = $urandom;
        b_m[k][i] = $urandom;
      end
  endtask

  // Called at a negedge with the engine idle or done; returns the cycle stamp of the last accept.
  task automatic feed(input int k, input bit sgn, input bit accm, input int bub, output int last_cyc);
    int kk, guard;
    bit accepted;
    kk = 0;
    guard = 0;
    start_i  = 1'b1;
    k_len_i  = 9'(k);
    signed_i = sgn;
    acc_i    = accm;
    @(negedge clk);
    last_cyc = cyc;
    while (kk < k_eff(k) && guard < 4000) begin
      guard++;
      start_i  = ($urandom_range(3) == 0);
      k_len_i  = 9'($urandom_range(511));
      signed_i = ~sgn;
      acc_i    = ~accm;
      a_col_i  = {$urandom, $urandom, $urandom, $urandom};
      b_row_i  = {$urandom, $urandom, $urandom, $urandom};
      in_valid_i = ($urandom_range(99) >= bub);
      if (in_valid_i)
        for (int i = 0; i < N; i++) begin
          a_col_i[i*DW +: DW] = a_m[i][kk];
          b_row_i[i*DW +: DW] = b_m[kk][i];
        end
      accepted = in_valid_i && in_ready_o;
      @(negedge clk);
      if (accepted) begin
        kk++;
        last_cyc = cyc;
      end
    end
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    check_val("beats_accepted", AW'(kk), AW'(k_eff(k)));
  endtask

  task automatic finish(input string tag, input int last_cyc, input bit chk_lat);
    int guard;
    guard = 0;
    while (!done_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_val({tag, "_done"}, AW'(done_o), AW'(1));
    if (chk_lat) check_val({tag, "_latency"}, AW'(cyc - last_cyc), AW'(LAT));
    repeat (2) @(negedge clk);
    check_val({tag, "_busy"}, AW'(busy_o), AW'(0));
    check_val({tag, "_ready"}, AW'(in_ready_o), AW'(0));
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check_val($sformatf("%s_c%0d%0d", tag, i, j), res_o[(i*N+j)*AW +: AW], exp_c[i][j]);
  endtask

  task automatic run(input string tag, input int k, input bit sgn, input bit accm, input int bub);
    int lc;
    feed(k, sgn, accm, bub, lc);
    model_job(k, sgn, accm);
    finish(tag, lc, k_eff(k) > 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lc;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) exp_c[i][j] = '0;

    repeat (3) @(negedge clk);
    check_val("rst_ready", AW'(in_ready_o), AW'(0));
    check_val("rst_busy", AW'(busy_o), AW'(0));
    check_val("rst_done", AW'(done_o), AW'(0));
    check_val("rst_res", AW'(|res_o), AW'(0));
    rst_i = 1'b0;
    @(negedge clk);

    fill_t1();
    run("t1", 4, 1'b0, 1'b0, 0);
    check_val("t1_c00_const", res_o[0*AW +: AW], AW'(10));
    check_val("t1_c11_const", res_o[5*AW +: AW], AW'(52));
    check_val("t1_c33_const", res_o[15*AW +: AW], AW'(232));

    run("t2", 4, 1'b0, 1'b0, 50);
    check_val("t2_c33_const", res_o[15*AW +: AW], AW'(232));

    fill_const(32'hFFFF_FFFD, 32'd5);
    run("t3", 8, 1'b1, 1'b0, 20);
    check_val("t3_c21_const", res_o[9*AW +: AW], {AW{1'b1}} - AW'(119));

    fill_t1();
    run("t4a", 4, 1'b0, 1'b0, 0);
    run("t4b", 4, 1'b0, 1'b1, 30);
    check_val("t4b_c33_const", res_o[15*AW +: AW], AW'(464));
    run("t4c", 4, 1'b0, 1'b0, 30);
    check_val("t4c_c33_const", res_o[15*AW +: AW], AW'(232));

    feed(0, 1'b0, 1'b0, 0, lc);
    check_val("t5_done_next", AW'(done_o), AW'(1));
    check_val("t5_ready", AW'(in_ready_o), AW'(0));
    model_job(0, 1'b0, 1'b0);
    finish("t5", lc, 1'b0);

    fill_t1();
    feed(4, 1'b0, 1'b0, 0, lc);
    repeat (3) @(negedge clk);
    check_val("t6_drain_busy", AW'(busy_o), AW'(1));
    #1 rst_i = 1'b1;
    #1;
    check_val("t6_rst_busy", AW'(busy_o), AW'(0));
    check_val("t6_rst_done", AW'(done_o), AW'(0));
    check_val("t6_rst_res", AW'(|res_o), AW'(0));
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) exp_c[i][j] = '0;
    @(negedge clk);
    run("t6", 4, 1'b0, 1'b1, 0);

    for (int r = 0; r < 6; r++) begin
      fill_rand();
      run($sformatf("rnd%0d", r), int'($urandom_range(1, 12)), bit'($urandom_range(1)),
          bit'($urandom_range(1)), 40);
    end

    fill_rand();
    run("clamp", 300, 1'b1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
